// File: rtl/stopwatch_sequencer.sv
// Run-control sequencer for the BCD stopwatch: button conditioning plus IDLE/RUN/PAUSE/LAP control.
// Define STOPWATCH_DEBOUNCE_EN to add per-button debounce counters (DEBOUNCE_CYCLES, DB_W).
module stopwatch_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_W            = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_Button,
   input  logic       stop_Button,
   input  logic       lap_Button,
   input  logic       clear_Button,
   input  logic       max_Reached,
   output logic       count_Enable,
   output logic       counter_Clear,
   output logic       lap_Latch,
   output logic       display_Hold,
   output logic [1:0] run_State
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_LAP   = 2;
   localparam int B_CLEAR = 3;

   // Debounce counter must be able to reach DEBOUNCE_CYCLES-1.
   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > (64'd1 << DB_W)) begin : g_param_check
      $error("stopwatch_sequencer: DB_W too narrow for DEBOUNCE_CYCLES");
   end

   logic [3:0] btn_raw;
   logic [3:0] press;

   assign btn_raw = {clear_Button, lap_Button, stop_Button, start_Button};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic sync1_q, sync2_q;
         logic db_level;
         logic db_prev_q;
         logic press_q, press_d;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
            end else begin
               sync1_q <= btn_raw[gi];
               sync2_q <= sync1_q;
            end
         end

`ifdef STOPWATCH_DEBOUNCE_EN
         logic            db_q, db_d;
         logic [DB_W-1:0] cnt_q, cnt_d;

         // Count consecutive disagreeing samples; any agreeing sample restarts the count.
         always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (sync2_q != db_q) begin
               if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  db_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               db_q  <= 1'b0;
               cnt_q <= '0;
            end else begin
               db_q  <= db_d;
               cnt_q <= cnt_d;
            end
         end

         assign db_level = db_q;
`else
         assign db_level = sync2_q;
`endif

         always_comb begin
            press_d = db_level & ~db_prev_q;
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               db_prev_q <= 1'b0;
               press_q   <= 1'b0;
            end else begin
               db_prev_q <= db_level;
               press_q   <= press_d;
            end
         end

         assign press[gi] = press_q;
      end
   endgenerate

   state_t state_q, state_d;
   logic   clear_q, clear_d;
   logic   latch_q, latch_d;

   // Each branch tests legal presses in clear > stop > start > lap order.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      latch_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press[B_CLEAR]) begin
               clear_d = 1'b1;
            end else if (press[B_START]) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (max_Reached || press[B_STOP]) begin
               state_d = ST_PAUSE;
            end else if (press[B_LAP]) begin
               state_d = ST_LAP;
               latch_d = 1'b1;
            end
         end
         ST_LAP: begin
            if (max_Reached || press[B_STOP]) begin
               state_d = ST_PAUSE;
            end else if (press[B_LAP]) begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (press[B_CLEAR]) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else if (press[B_START] && !max_Reached) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         clear_q <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         latch_q <= latch_d;
      end
   end

   // Masking with max_Reached keeps the chain from wrapping past 99.99.
   assign count_Enable  = tick & ((state_q == ST_RUN) | (state_q == ST_LAP)) & ~max_Reached;
   assign display_Hold  = (state_q == ST_LAP);
   assign run_State     = state_q;
   assign counter_Clear = clear_q;
   assign lap_Latch     = latch_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer; works with STOPWATCH_DEBOUNCE_EN defined or not.
module tb_stopwatch_sequencer;

   localparam int DEB = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       start_b = 1'b0, stop_b = 1'b0, lap_b = 1'b0, clear_b = 1'b0;
   logic       max_r = 1'b0;
   logic       count_Enable, counter_Clear, lap_Latch, display_Hold;
   logic [1:0] run_State;

   int vec_cnt = 0;
   int err_cnt = 0;

   stopwatch_sequencer #(.DEBOUNCE_CYCLES(DEB), .DB_W(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .tick          (tick),
      .start_Button  (start_b),
      .stop_Button   (stop_b),
      .lap_Button    (lap_b),
      .clear_Button  (clear_b),
      .max_Reached   (max_r),
      .count_Enable  (count_Enable),
      .counter_Clear (counter_Clear),
      .lap_Latch     (lap_Latch),
      .display_Hold  (display_Hold),
      .run_State     (run_State)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // mask = {clear, lap, stop, start}; returns on the cycle the resulting state is visible
   task automatic push(input logic [3:0] m);
      {clear_b, lap_b, stop_b, start_b} = m;
      step(LAT + 1);
      $display("press %b -> state %b clr %b latch %b hold %b", m, run_State, counter_Clear, lap_Latch, display_Hold);
   endtask

   task automatic release_all();
      {clear_b, lap_b, stop_b, start_b} = 4'b0000;
      step(LAT + 2);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         tick = ~tick;
         step(1);
      end
      tick = 1'b1;
      #1;
      vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL rst_state got %b exp 00", run_State); end
      vec_cnt++; if (count_Enable !== 1'b0) begin err_cnt++; $display("FAIL rst_ce got %b exp 0", count_Enable); end
      vec_cnt++; if (counter_Clear !== 1'b0) begin err_cnt++; $display("FAIL rst_clr got %b exp 0", counter_Clear); end
      vec_cnt++; if (lap_Latch !== 1'b0) begin err_cnt++; $display("FAIL rst_latch got %b exp 0", lap_Latch); end
      vec_cnt++; if (display_Hold !== 1'b0) begin err_cnt++; $display("FAIL rst_hold got %b exp 0", display_Hold); end
      tick = 1'b0;
      start_b = 1'b1;
      reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         logic [1:0] exp_st;
         step(1);
         exp_st = (i >= LAT + 1) ? 2'b01 : 2'b00;
         vec_cnt++; if (run_State !== exp_st) begin err_cnt++; $display("FAIL start_latency cyc %0d got %b exp %b", i, run_State, exp_st); end
      end
      $display("reset/start done, state %b", run_State);
      release_all();
   endtask

   task automatic test_reset_midway();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL mid_rst_state got %b exp 00", run_State); end
      start_b = 1'b1;
      step(LAT - 2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      for (int i = 1; i <= LAT + 1; i++) begin
         logic [1:0] exp_st;
         step(1);
         exp_st = (i == LAT + 1) ? 2'b01 : 2'b00;
         vec_cnt++; if (run_State !== exp_st) begin err_cnt++; $display("FAIL mid_rst cyc %0d got %b exp %b", i, run_State, exp_st); end
      end
      release_all();
   endtask

   task automatic test_run_lap();
      for (int i = 0; i < 5; i++) begin
         tick = 1'b1;
         #1;
         vec_cnt++; if (count_Enable !== 1'b1) begin err_cnt++; $display("FAIL run_tick %0d got %b exp 1", i, count_Enable); end
         step(1);
         tick = 1'b0;
         #1;
         vec_cnt++; if (count_Enable !== 1'b0) begin err_cnt++; $display("FAIL run_notick %0d got %b exp 0", i, count_Enable); end
         step(1);
      end
      push(4'b0100);
      vec_cnt++; if (run_State !== 2'b11) begin err_cnt++; $display("FAIL lap_state got %b exp 11", run_State); end
      vec_cnt++; if (lap_Latch !== 1'b1) begin err_cnt++; $display("FAIL lap_latch got %b exp 1", lap_Latch); end
      vec_cnt++; if (display_Hold !== 1'b1) begin err_cnt++; $display("FAIL lap_hold got %b exp 1", display_Hold); end
      step(1);
      vec_cnt++; if (lap_Latch !== 1'b0) begin err_cnt++; $display("FAIL lap_latch_width got %b exp 0", lap_Latch); end
      tick = 1'b1;
      #1;
      vec_cnt++; if (count_Enable !== 1'b1) begin err_cnt++; $display("FAIL lap_tick got %b exp 1", count_Enable); end
      step(1);
      tick = 1'b0;
      release_all();
      push(4'b0100);
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL lap2_state got %b exp 01", run_State); end
      vec_cnt++; if (display_Hold !== 1'b0) begin err_cnt++; $display("FAIL lap2_hold got %b exp 0", display_Hold); end
      vec_cnt++; if (lap_Latch !== 1'b0) begin err_cnt++; $display("FAIL lap2_latch got %b exp 0", lap_Latch); end
      release_all();
   endtask

   task automatic test_pause_clear();
      int ce_seen;
      push(4'b0010);
      vec_cnt++; if (run_State !== 2'b10) begin err_cnt++; $display("FAIL stop_state got %b exp 10", run_State); end
      release_all();
      ce_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick = 1'b1;
         #1;
         if (count_Enable === 1'b1) ce_seen++;
         step(1);
         tick = 1'b0;
         step(1);
      end
      vec_cnt++; if (ce_seen !== 0) begin err_cnt++; $display("FAIL pause_ce got %0d enables exp 0", ce_seen); end
      push(4'b1000);
      vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL pclear_state got %b exp 00", run_State); end
      vec_cnt++; if (counter_Clear !== 1'b1) begin err_cnt++; $display("FAIL pclear_pulse got %b exp 1", counter_Clear); end
      step(1);
      vec_cnt++; if (counter_Clear !== 1'b0) begin err_cnt++; $display("FAIL pclear_width got %b exp 0", counter_Clear); end
      release_all();
      push(4'b0001);
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL restart_state got %b exp 01", run_State); end
      release_all();
      push(4'b1000);
      vec_cnt++; if (counter_Clear !== 1'b0) begin err_cnt++; $display("FAIL runclear_pulse got %b exp 0", counter_Clear); end
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL runclear_state got %b exp 01", run_State); end
      release_all();
   endtask

   task automatic test_simultaneous();
      push(4'b0110);
      vec_cnt++; if (run_State !== 2'b10) begin err_cnt++; $display("FAIL stoplap_state got %b exp 10", run_State); end
      vec_cnt++; if (lap_Latch !== 1'b0) begin err_cnt++; $display("FAIL stoplap_latch got %b exp 0", lap_Latch); end
      release_all();
      push(4'b1001);
      vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL clrstart_state got %b exp 00", run_State); end
      vec_cnt++; if (counter_Clear !== 1'b1) begin err_cnt++; $display("FAIL clrstart_pulse got %b exp 1", counter_Clear); end
      release_all();
      push(4'b1000);
      vec_cnt++; if (counter_Clear !== 1'b1) begin err_cnt++; $display("FAIL idleclear_pulse got %b exp 1", counter_Clear); end
      vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL idleclear_state got %b exp 00", run_State); end
      release_all();
   endtask

   task automatic test_bounce();
      int entries;
      logic [1:0] prev;
      entries = 0;
      prev = run_State;
      for (int i = 0; i < 20; i++) begin
         start_b = ((i / 2) % 2) == 0;
         step(1);
         if (prev == 2'b00 && run_State == 2'b01) entries++;
         prev = run_State;
`ifdef STOPWATCH_DEBOUNCE_EN
         vec_cnt++; if (run_State !== 2'b00) begin err_cnt++; $display("FAIL bounce_reject cyc %0d got %b exp 00", i, run_State); end
`endif
      end
      start_b = 1'b1;
      for (int i = 1; i <= LAT + 6; i++) begin
         step(1);
         if (prev == 2'b00 && run_State == 2'b01) entries++;
         prev = run_State;
`ifdef STOPWATCH_DEBOUNCE_EN
         vec_cnt++;
         if (run_State !== ((i >= LAT + 1) ? 2'b01 : 2'b00)) begin
            err_cnt++; $display("FAIL bounce_settle cyc %0d got %b", i, run_State);
         end
`endif
      end
      vec_cnt++; if (entries !== 1) begin err_cnt++; $display("FAIL bounce_entries got %0d exp 1", entries); end
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL bounce_final got %b exp 01", run_State); end
      release_all();
   endtask

   task automatic test_saturation();
      tick = 1'b1;
      max_r = 1'b1;
      #1;
      vec_cnt++; if (count_Enable !== 1'b0) begin err_cnt++; $display("FAIL sat_ce got %b exp 0", count_Enable); end
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL sat_pre got %b exp 01", run_State); end
      step(1);
      tick = 1'b0;
      vec_cnt++; if (run_State !== 2'b10) begin err_cnt++; $display("FAIL sat_state got %b exp 10", run_State); end
      push(4'b0001);
      vec_cnt++; if (run_State !== 2'b10) begin err_cnt++; $display("FAIL sat_start got %b exp 10", run_State); end
      release_all();
      max_r = 1'b0;
      push(4'b0001);
      vec_cnt++; if (run_State !== 2'b01) begin err_cnt++; $display("FAIL unsat_start got %b exp 01", run_State); end
      release_all();
      push(4'b0100);
      release_all();
      vec_cnt++; if (display_Hold !== 1'b1) begin err_cnt++; $display("FAIL satlap_pre got %b exp 1", display_Hold); end
      max_r = 1'b1;
      step(1);
      vec_cnt++; if (run_State !== 2'b10) begin err_cnt++; $display("FAIL satlap_state got %b exp 10", run_State); end
      vec_cnt++; if (display_Hold !== 1'b0) begin err_cnt++; $display("FAIL satlap_hold got %b exp 0", display_Hold); end
      max_r = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_midway();
      test_run_lap();
      test_pause_clear();
      test_simultaneous();
      test_bounce();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
